rgb2hsv_stream: RTL and testbench

//  Parametrised, fully pipelined RGB->HSV converter with valid/ready flow control and a sideband tag.

---
 rtl/hsv_pkg.sv | 21 ++
 rtl/rgb2hsv_stream_if.sv | 30 +++
 rtl/hsv_div_pipe.sv | 86 ++++++++
 rtl/rgb2hsv_stream.sv | 162 ++++++++++++++++
 tb/tb_rgb2hsv_stream.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hsv_pkg.sv
// Shared types and helpers for the RGB->HSV stream converter.
package hsv_pkg;

  // Hue sector, chosen by which component holds the maximum (ties: r, then g, then b).
  typedef enum logic [1:0] {
    SEC_R = 2'd0,
    SEC_G = 2'd1,
    SEC_B = 2'd2
  } sector_e;

  // Full-scale value of a component of width cw (255 at cw=8).
  function automatic int h_full(input int cw);
    return (1 << cw) - 1;
  endfunction

  // Hue offset of a sector: 0, 1/3 and 2/3 of the hue circle.
  function automatic int sect_off(input int cw, input sector_e sec);
    return int'(sec) * (h_full(cw) / 3);
  endfunction

endpackage

// File: rtl/rgb2hsv_stream_if.sv
// Pixel stream bundle: RGB+tag in, HSV+tag out, each with valid/ready.
interface rgb2hsv_stream_if #(
  parameter int CW    = 8,
  parameter int TAG_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    in_r;
  logic [CW-1:0]    in_g;
  logic [CW-1:0]    in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_h;
  logic [CW-1:0]    out_s;
  logic [CW-1:0]    out_v;
  logic [TAG_W-1:0] out_tag;

  // Pixel source / result sink side.
  modport master (
    output in_valid, in_r, in_g, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_h, out_s, out_v, out_tag
  );

  // Converter side.
  modport slave (
    input  in_valid, in_r, in_g, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_h, out_s, out_v, out_tag
  );
endinterface

// File: rtl/hsv_div_pipe.sv
// Pipelined restoring divider: one quotient bit per stage, MSB first, floor
// division. The caller guarantees the quotient fits in QW bits. A payload and
// a valid bit travel alongside; every stage shifts only when en=1.
module hsv_div_pipe #(
  parameter int NW = 16,
  parameter int DW = 8,
  parameter int QW = 8,
  parameter int PW = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          in_valid,
  input  logic [NW-1:0] in_num,
  input  logic [DW-1:0] in_den,
  input  logic [PW-1:0] in_pay,
  output logic          out_valid,
  output logic [QW-1:0] out_q,
  output logic [PW-1:0] out_pay
);
  // Wide enough for the numerator and for den shifted up by QW-1.
  localparam int WW = (NW > DW + QW) ? NW : DW + QW;

  wire [WW-1:0] rem_c [QW];
  wire [DW-1:0] den_c [QW];
  wire [QW-1:0] q_c   [QW+1];
  wire [PW-1:0] pay_c [QW+1];
  wire          vld_c [QW+1];

  assign rem_c[0] = WW'(in_num);
  assign den_c[0] = in_den;
  assign q_c[0]   = '0;
  assign pay_c[0] = in_pay;
  assign vld_c[0] = in_valid;

  for (genvar k = 0; k < QW; k++) begin : g_stage
    localparam int B = QW - 1 - k;
    logic [WW-1:0] trial;
    logic          take;
    logic [QW-1:0] q_r;
    logic [PW-1:0] pay_r;
    logic          vld_r;

    assign trial = WW'(den_c[k]) << B;
    assign take  = (rem_c[k] >= trial);

    // Stage valid bit: cleared by reset, shifts with the pipe.
    always_ff @(posedge clock) begin
      if (reset) vld_r <= 1'b0;
      else if (en) vld_r <= vld_c[k];
    end

    // Resolve quotient bit B and carry the payload.
    always_ff @(posedge clock) begin
      if (en) begin
        q_r   <= q_c[k] | (QW'(take) << B);
        pay_r <= pay_c[k];
      end
    end

    assign q_c[k+1]   = q_r;
    assign pay_c[k+1] = pay_r;
    assign vld_c[k+1] = vld_r;

    // The last stage needs no remainder or divisor downstream.
    if (k < QW - 1) begin : g_carry
      logic [WW-1:0] rem_r;
      logic [DW-1:0] den_r;

      // Partial remainder and divisor for the next bit.
      always_ff @(posedge clock) begin
        if (en) begin
          rem_r <= take ? (rem_c[k] - trial) : rem_c[k];
          den_r <= den_c[k];
        end
      end

      assign rem_c[k+1] = rem_r;
      assign den_c[k+1] = den_r;
    end
  end

  assign out_valid = vld_c[QW];
  assign out_q     = q_c[QW];
  assign out_pay   = pay_c[QW];
endmodule

// File: rtl/rgb2hsv_stream.sv
// Fully pipelined RGB->HSV converter, CW+4 stages, carrying a sideband tag.
//
// Handshake: a transfer happens on a side when valid & ready are both high at
// a rising edge. The whole pipe (data and valid bits) advances together when
// adv = !out_valid | out_ready, so bubbles are kept and the output holds while
// stalled. in_ready = adv & !reset is combinational from out_ready.
module rgb2hsv_stream
  import hsv_pkg::*;
#(
  parameter int CW    = 8,
  parameter int TAG_W = 20
) (
  input logic             clock,
  input logic             reset,
  rgb2hsv_stream_if.slave bus
);
  localparam int NW  = 2 * CW;
  localparam int HW  = CW + 3;
  localparam int SPW = CW + TAG_W;  // sat payload: v, tag
  localparam int HPW = CW + 1;      // hue payload: off, neg
  localparam logic [NW-1:0] HF = NW'(h_full(CW));

  logic adv;
  assign adv          = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv & !reset;

  // S1 registers
  logic             v1;
  logic [CW-1:0]    r1, g1, b1;
  logic [TAG_W-1:0] t1;

  // S1: capture the incoming pixel (a bubble when in_valid is low).
  always_ff @(posedge clock) begin
    if (reset) v1 <= 1'b0;
    else if (adv) begin
      v1 <= bus.in_valid;
      r1 <= bus.in_r;
      g1 <= bus.in_g;
      b1 <= bus.in_b;
      t1 <= bus.in_tag;
    end
  end

  // Sector, max/min and signed hue difference of the S1 pixel.
  sector_e       sec_c;
  logic [CW-1:0] max_c, min_c;
  logic [CW:0]   diff_c;

  // Max tie priority r > g > b decides the sector.
  always_comb begin
    sec_c  = SEC_R;
    max_c  = r1;
    diff_c = {1'b0, g1} - {1'b0, b1};
    if (r1 >= g1 && r1 >= b1) begin
      sec_c  = SEC_R;
    end else if (g1 >= b1) begin
      sec_c  = SEC_G;
      max_c  = g1;
      diff_c = {1'b0, b1} - {1'b0, r1};
    end else begin
      sec_c  = SEC_B;
      max_c  = b1;
      diff_c = {1'b0, r1} - {1'b0, g1};
    end
    min_c = r1;
    if (g1 < min_c) min_c = g1;
    if (b1 < min_c) min_c = b1;
  end

  // S2 registers
  logic             v2, neg2;
  logic [CW-1:0]    max2, delta2, adiff2;
  sector_e          sec2;
  logic [TAG_W-1:0] t2;

  // S2: register extremes, delta, |diff| and its sign.
  always_ff @(posedge clock) begin
    if (reset) v2 <= 1'b0;
    else if (adv) begin
      v2     <= v1;
      max2   <= max_c;
      delta2 <= max_c - min_c;
      adiff2 <= diff_c[CW] ? CW'(-diff_c) : diff_c[CW-1:0];
      neg2   <= diff_c[CW];
      sec2   <= sec_c;
      t2     <= t1;
    end
  end

  // S3 registers
  logic             v3, neg3;
  logic [NW-1:0]    s_num3, h_num3;
  logic [CW-1:0]    s_den3, max3, off3;
  logic [HW-1:0]    h_den3;
  logic [TAG_W-1:0] t3;

  // S3: dividends/divisors; zero divisors are replaced so gray stays 0/0.
  always_ff @(posedge clock) begin
    if (reset) v3 <= 1'b0;
    else if (adv) begin
      v3     <= v2;
      s_num3 <= NW'(delta2) * HF;
      s_den3 <= (max2 == '0) ? CW'(1) : max2;
      h_num3 <= NW'(adiff2) * HF;
      h_den3 <= (delta2 == '0) ? HW'(6) : HW'(delta2) * HW'(6);
      off3   <= CW'(sect_off(CW, sec2));
      neg3   <= neg2;
      max3   <= max2;
      t3     <= t2;
    end
  end

  logic           sat_vld, hue_vld;
  logic [CW-1:0]  s_q, h_q;
  logic [SPW-1:0] sat_pay;
  logic [HPW-1:0] hue_pay;

  hsv_div_pipe #(.NW(NW), .DW(CW), .QW(CW), .PW(SPW)) u_sat_div (
    .clock    (clock),
    .reset    (reset),
    .en       (adv),
    .in_valid (v3),
    .in_num   (s_num3),
    .in_den   (s_den3),
    .in_pay   ({max3, t3}),
    .out_valid(sat_vld),
    .out_q    (s_q),
    .out_pay  (sat_pay)
  );

  hsv_div_pipe #(.NW(NW), .DW(HW), .QW(CW), .PW(HPW)) u_hue_div (
    .clock    (clock),
    .reset    (reset),
    .en       (adv),
    .in_valid (v3),
    .in_num   (h_num3),
    .in_den   (h_den3),
    .in_pay   ({off3, neg3}),
    .out_valid(hue_vld),
    .out_q    (h_q),
    .out_pay  (hue_pay)
  );

  // Output stage: hue wraps modulo 2**CW; data only updates for real pixels.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_h     <= '0;
      bus.out_s     <= '0;
      bus.out_v     <= '0;
      bus.out_tag   <= '0;
    end else if (adv) begin
      bus.out_valid <= sat_vld & hue_vld;
      if (sat_vld) begin
        bus.out_s   <= s_q;
        bus.out_v   <= sat_pay[SPW-1 -: CW];
        bus.out_tag <= sat_pay[TAG_W-1:0];
        bus.out_h   <= hue_pay[0] ? (hue_pay[CW:1] - h_q) : (hue_pay[CW:1] + h_q);
      end
    end
  end
endmodule

// File: tb/tb_rgb2hsv_stream.sv
// Bench for rgb2hsv_stream: random and directed pixels, behavioural HSV model,
// scoreboard on every output transfer, stall-hold, latency and reset checks.
module tb_rgb2hsv_stream;
  localparam int CW    = 8;
  localparam int TAG_W = 20;
  localparam int LAT   = CW + 4;
  localparam int W     = TAG_W + 3 * CW;
  localparam int HFI   = (1 << CW) - 1;
  localparam int SECTI = HFI / 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  rgb2hsv_stream_if #(.CW(CW), .TAG_W(TAG_W)) bus ();

  rgb2hsv_stream #(.CW(CW), .TAG_W(TAG_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  logic [TAG_W-1:0] tag_ctr = '0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
  logic lat_chk = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3*CW-1:0] ref_hsv(input int r, input int g, input int b);
    int mx, mn, d, diff, off, hq, h, s;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    d = mx - mn;
    h = 0;
    s = 0;
    if (d != 0) begin
      s = d * HFI / mx;
      if (r == mx)      begin diff = g - b; off = 0;         end
      else if (g == mx) begin diff = b - r; off = SECTI;     end
      else              begin diff = r - g; off = 2 * SECTI; end
      hq = ((diff < 0) ? -diff : diff) * HFI / (6 * d);
      h  = (diff < 0) ? off - hq : off + hq;
      h  = ((h % (HFI + 1)) + (HFI + 1)) % (HFI + 1);
    end
    return {h[CW-1:0], s[CW-1:0], mx[CW-1:0]};
  endfunction

  // ---------------- scoreboard / compare ----------------
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  logic [W-1:0] e_item;
  int           c0;
  logic         stall_prev = 1'b0;
  logic         after_rst  = 1'b0;
  logic [W:0]   held;

  always @(negedge clock) begin
    if (reset) begin
      check("in_ready_in_reset", 64'(bus.in_ready), 64'd0);
      exp_q.delete();
      lat_q.delete();
      stall_prev = 1'b0;
      after_rst  = 1'b1;
    end else begin
      if (after_rst) begin
        check("out_valid_after_reset", 64'(bus.out_valid), 64'd0);
        after_rst = 1'b0;
      end
      if (stall_prev)
        check("stall_hold", 64'({bus.out_valid, bus.out_tag, bus.out_h, bus.out_s, bus.out_v}), 64'(held));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output_tag", 64'(bus.out_tag), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e_item = exp_q.pop_front();
          c0     = lat_q.pop_front();
          check("no_x", 64'($isunknown({bus.out_tag, bus.out_h, bus.out_s, bus.out_v})), 64'd0);
          check("tag_h_s_v", 64'({bus.out_tag, bus.out_h, bus.out_s, bus.out_v}), 64'(e_item));
          if (lat_chk) check("latency", 64'(cyc - c0), 64'(LAT));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({bus.in_tag, ref_hsv(bus.in_r, bus.in_g, bus.in_b)});
        lat_q.push_back(cyc);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = {bus.out_valid, bus.out_tag, bus.out_h, bus.out_s, bus.out_v};
    end
  end

  // ---------------- driver tasks ----------------
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input int r, input int g, input int b);
    int   guard;
    logic ok;
    bus.in_valid = 1'b1;
    bus.in_r     = CW'(r);
    bus.in_g     = CW'(g);
    bus.in_b     = CW'(b);
    bus.in_tag   = tag_ctr;
    guard = 0;
    ok    = 1'b0;
    while (!ok && guard < 1000) begin
      @(negedge clock);
      ok = bus.in_ready;
      @(posedge clock);
      #1;
      guard++;
    end
    check("send_accepted", 64'(ok), 64'd1);
    bus.in_valid = 1'b0;
    tag_ctr++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_random();
    int r, g, b;
    r = $urandom_range(0, HFI);
    g = $urandom_range(0, HFI);
    b = $urandom_range(0, HFI);
    if ($urandom_range(0, 7) == 0) begin g = r; b = r; end
    send(r, g, b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clock);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    idle(3);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int outs;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_r      = '0;
    bus.in_g      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // Hand-computed values pin the model.
    check("model_red",   64'(ref_hsv(255, 0, 0)),     64'({8'd0,   8'd255, 8'd255}));
    check("model_green", 64'(ref_hsv(0, 255, 0)),     64'({8'd85,  8'd255, 8'd255}));
    check("model_blue",  64'(ref_hsv(0, 0, 255)),     64'({8'd170, 8'd255, 8'd255}));
    check("model_gray",  64'(ref_hsv(128, 128, 128)), 64'({8'd0,   8'd0,   8'd128}));
    check("model_black", 64'(ref_hsv(0, 0, 0)),       64'd0);
    check("model_wrap",  64'(ref_hsv(255, 0, 51)),    64'({8'd248, 8'd255, 8'd255}));
    check("model_gsec",  64'(ref_hsv(10, 200, 100)),  64'({8'd105, 8'd242, 8'd200}));

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_hsv",   64'({bus.out_h, bus.out_s, bus.out_v}), 64'd0);
    check("reset_out_tag",   64'(bus.out_tag), 64'd0);
    check("ready_after_reset", 64'(bus.in_ready), 64'd1);
    @(posedge clock);
    #1;

    // Primaries back-to-back, with latency checking.
    lat_chk = 1'b1;
    send(255, 0, 0);
    send(0, 255, 0);
    send(0, 0, 255);
    drain();

    // Gray, black, wrap and green-sector pixels.
    send(128, 128, 128);
    send(0, 0, 0);
    send(255, 0, 51);
    send(10, 200, 100);
    drain();
    lat_chk = 1'b0;

    // Random stream with random backpressure and input gaps.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send_random();
      idle($urandom_range(0, 2));
    end
    drain();
    rdy_mode = 0;
    idle(2);

    // Fill the pipe against a blocked sink, then release it.
    rdy_mode = 2;
    idle(2);
    fork
      begin
        for (int i = 0; i < 24; i++) send_random();
      end
      begin
        repeat (30) @(negedge clock);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("full_out_valid", 64'(bus.out_valid), 64'd1);
        rdy_mode = 0;
        @(posedge clock);
        @(posedge clock);
        outs = 0;
        for (int i = 0; i < 12; i++) begin
          @(negedge clock);
          if (bus.out_valid && bus.out_ready) outs++;
        end
        check("release_rate", 64'(outs), 64'd12);
      end
    join
    drain();

    // One-cycle reset mid-stream: old pixels vanish, new ones keep latency.
    lat_chk = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) send_random();
      end
      begin
        idle(6);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
      end
    join
    drain();
    lat_chk = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
